eth_tx_fsm: RTL

Downstream stage of the per-port receive FSM and its packet FIFO. It pops one packed packet word from the FIFO and checks its framing and CRC field. Accepted packets are serialised onto the 32-bit egress port as four words (dest, src, data, crc) with outsop/outeop, under a valid/ready handshake. Rejected packets are dropped and counted.

---
 rtl/eth_pkg.sv | 48 ++++
 rtl/eth_tx_fsm_sat_cnt.sv | 37 +++
 rtl/eth_tx_fsm.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the egress path: packet field layout inside a FIFO
// entry, the transmit FSM state type, and the addresses carried over from
// the old defines header.
package eth_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int PKT_WIDTH  = 4 * DATA_WIDTH + 2;

  // FIFO entry layout: {eop, crc, src, data, dest, sop}
  localparam int SOP_BIT  = 0;
  localparam int DEST_LSB = 1;
  localparam int DATA_LSB = 33;
  localparam int SRC_LSB  = 65;
  localparam int CRC_LSB  = 97;
  localparam int EOP_BIT  = 129;

  // Fixed CRC pattern a well-formed packet must carry
  localparam logic [DATA_WIDTH-1:0] CRC_DATA = 32'hC704_DD7B;

  // Port MAC-side and IP-side addresses
  localparam logic [DATA_WIDTH-1:0] PORT_A_ADDR    = 32'h0000_ABCD;
  localparam logic [DATA_WIDTH-1:0] PORT_B_ADDR    = 32'h0000_BCDE;
  localparam logic [DATA_WIDTH-1:0] PORT_C_ADDR    = 32'h0000_CDEF;
  localparam logic [DATA_WIDTH-1:0] PORT_D_ADDR    = 32'h0000_DEF0;
  localparam logic [DATA_WIDTH-1:0] IP_PORT_A_ADDR = 32'hC0A8_0001;
  localparam logic [DATA_WIDTH-1:0] IP_PORT_B_ADDR = 32'hC0A8_0002;
  localparam logic [DATA_WIDTH-1:0] IP_PORT_C_ADDR = 32'hC0A8_0003;
  localparam logic [DATA_WIDTH-1:0] IP_PORT_D_ADDR = 32'hC0A8_0004;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CHECK   = 3'd2,
    TX_DEST = 3'd3,
    TX_SRC  = 3'd4,
    TX_DATA = 3'd5,
    TX_CRC  = 3'd6
  } tx_state_t;

  // Extract one DATA_WIDTH field from a packed FIFO entry
  function automatic logic [DATA_WIDTH-1:0] pkt_field(
    input logic [PKT_WIDTH-1:0] pkt,
    input int                   lsb
  );
    return pkt[lsb +: DATA_WIDTH];
  endfunction

endpackage

// File: rtl/eth_tx_fsm_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones
// instead of wrapping.
module eth_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, increment only below all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/eth_tx_fsm.sv
// Egress stage: pops one packed packet from the FIFO, validates framing and
// CRC, then serialises dest/src/data/crc onto the egress port.
//
// Egress handshake: a word transfers on a clock edge where outvalid and
// out_ready are both high. outvalid never depends on out_ready, and while
// outvalid is high without out_ready, outdata/outsop/outeop stay frozen.
module eth_tx_fsm
  import eth_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [PKT_WIDTH-1:0]  fifo_rd_data,
  output logic [DATA_WIDTH-1:0] outdata,
  output logic                  outvalid,
  output logic                  outsop,
  output logic                  outeop,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  tx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output tx_state_t             dbg_state
);

  tx_state_t             state_q, state_d;
  logic [PKT_WIDTH-1:0]  pkt_q, pkt_d;
  logic [DATA_WIDTH-1:0] outdata_q, outdata_d;
  logic                  outvalid_q, outvalid_d;
  logic                  outsop_q, outsop_d;
  logic                  outeop_q, outeop_d;
  logic                  tx_inc;
  logic                  drop_inc;
  logic                  pkt_ok;

  assign pkt_ok = pkt_q[SOP_BIT] && pkt_q[EOP_BIT] &&
                  (pkt_field(pkt_q, CRC_LSB) == CRC_DATA);

  // Next-state and output decode; the FIFO pop is only ever raised in IDLE
  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    outdata_d  = outdata_q;
    outvalid_d = outvalid_q;
    outsop_d   = outsop_q;
    outeop_d   = outeop_q;
    fifo_rd_en = 1'b0;
    tx_inc     = 1'b0;
    drop_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !rst) begin
          fifo_rd_en = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        pkt_d   = fifo_rd_data;
        state_d = CHECK;
      end
      CHECK: begin
        if (pkt_ok) begin
          outdata_d  = pkt_field(pkt_q, DEST_LSB);
          outvalid_d = 1'b1;
          outsop_d   = 1'b1;
          state_d    = TX_DEST;
        end else begin
          drop_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      TX_DEST: begin
        if (out_ready) begin
          outdata_d = pkt_field(pkt_q, SRC_LSB);
          outsop_d  = 1'b0;
          state_d   = TX_SRC;
        end
      end
      TX_SRC: begin
        if (out_ready) begin
          outdata_d = pkt_field(pkt_q, DATA_LSB);
          state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (out_ready) begin
          outdata_d = pkt_field(pkt_q, CRC_LSB);
          outeop_d  = 1'b1;
          state_d   = TX_CRC;
        end
      end
      TX_CRC: begin
        if (out_ready) begin
          outvalid_d = 1'b0;
          outeop_d   = 1'b0;
          tx_inc     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, packet and egress registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pkt_q      <= '0;
      outdata_q  <= '0;
      outvalid_q <= 1'b0;
      outsop_q   <= 1'b0;
      outeop_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      outdata_q  <= outdata_d;
      outvalid_q <= outvalid_d;
      outsop_q   <= outsop_d;
      outeop_q   <= outeop_d;
    end
  end

  eth_sat_cnt #(.W(CNT_WIDTH)) u_tx_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (tx_inc),
    .cnt_o (tx_pkt_cnt)
  );

  eth_sat_cnt #(.W(CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (drop_inc),
    .cnt_o (drop_cnt)
  );

  assign outdata   = outdata_q;
  assign outvalid  = outvalid_q;
  assign outsop    = outsop_q;
  assign outeop    = outeop_q;
  assign dbg_state = state_q;

endmodule
